// File: rtl/cpu_icache_direct.sv
// Direct-mapped, one-word-per-line, read-only instruction cache with a tag handshake
// toward the fetch stage and a single request/ready read port toward memory.
module cpu_icache_direct #(
  parameter int LINES_LOG2 = 9
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_input_tag,
  output logic [7:0]  o_output_tag,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);
  localparam int TAG_W = 30 - LINES_LOG2;
  localparam int LINES = 1 << LINES_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_BUS, ST_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              out_tag_q, out_tag_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    bus_req_q, bus_req_d;
  logic [31:0]             bus_addr_q, bus_addr_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [LINES_LOG2-1:0]   sweep_q, sweep_d;
  logic [29:0]             req_addr_q, req_addr_d;
  logic [7:0]              req_tag_q, req_tag_d;

  logic                    valid_mem [LINES];
  logic [TAG_W-1:0]        tag_mem   [LINES];
  logic [31:0]             data_mem  [LINES];

  logic                    rd_en;
  logic [LINES_LOG2-1:0]   rd_idx;
  logic                    rd_valid_q;
  logic [TAG_W-1:0]        rd_tag_q;
  logic [31:0]             rd_data_q;
  logic                    line_we;
  logic                    valid_we;
  logic                    valid_wval;
  logic [LINES_LOG2-1:0]   wr_idx;
  logic [1:0]              unused_addr_bits;

  assign unused_addr_bits = i_address[1:0];

  always_comb begin
    state_d         = state_q;
    out_tag_d       = out_tag_q;
    rdata_d         = rdata_q;
    bus_req_d       = bus_req_q;
    bus_addr_d      = bus_addr_q;
    flush_pending_d = flush_pending_q;
    sweep_d         = sweep_q;
    req_addr_d      = req_addr_q;
    req_tag_d       = req_tag_q;
    rd_en           = 1'b0;
    rd_idx          = i_address[LINES_LOG2+1:2];
    line_we         = 1'b0;
    valid_we        = 1'b0;
    valid_wval      = 1'b0;
    wr_idx          = req_addr_q[LINES_LOG2-1:0];
    case (state_q)
      ST_IDLE: begin
        if (i_flush || flush_pending_q) begin
          state_d         = ST_FLUSH;
          flush_pending_d = 1'b0;
          sweep_d         = '0;
        end else if (i_input_tag != out_tag_q) begin
          req_addr_d = i_address[31:2];
          req_tag_d  = i_input_tag;
          rd_en      = 1'b1;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (i_flush) flush_pending_d = 1'b1;
        if (rd_valid_q && (rd_tag_q == req_addr_q[29:LINES_LOG2])) begin
          rdata_d   = rd_data_q;
          out_tag_d = req_tag_q;
          state_d   = ST_IDLE;
        end else begin
          bus_req_d  = 1'b1;
          bus_addr_d = {req_addr_q, 2'b00};
          state_d    = ST_BUS;
        end
      end
      ST_BUS: begin
        if (i_flush) flush_pending_d = 1'b1;
        if (i_bus_ready) begin
          line_we    = 1'b1;
          valid_we   = 1'b1;
          valid_wval = 1'b1;
          rdata_d    = i_bus_rdata;
          out_tag_d  = req_tag_q;
          bus_req_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Flush requests arriving mid-sweep are absorbed by the sweep itself.
        valid_we = 1'b1;
        wr_idx   = sweep_q;
        sweep_d  = sweep_q + 1'b1;
        if (&sweep_q) state_d = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q         <= ST_FLUSH;
      out_tag_q       <= '0;
      rdata_q         <= '0;
      bus_req_q       <= 1'b0;
      bus_addr_q      <= '0;
      flush_pending_q <= 1'b0;
      sweep_q         <= '0;
      req_addr_q      <= '0;
      req_tag_q       <= '0;
    end else begin
      state_q         <= state_d;
      out_tag_q       <= out_tag_d;
      rdata_q         <= rdata_d;
      bus_req_q       <= bus_req_d;
      bus_addr_q      <= bus_addr_d;
      flush_pending_q <= flush_pending_d;
      sweep_q         <= sweep_d;
      req_addr_q      <= req_addr_d;
      req_tag_q       <= req_tag_d;
    end
  end

  // Line storage: registered read, writes suppressed while reset is held.
  always_ff @(posedge i_clock) begin
    if (valid_we && !i_reset) valid_mem[wr_idx] <= valid_wval;
    if (rd_en) rd_valid_q <= valid_mem[rd_idx];
  end

  always_ff @(posedge i_clock) begin
    if (line_we && !i_reset) begin
      tag_mem[wr_idx]  <= req_addr_q[29:LINES_LOG2];
      data_mem[wr_idx] <= i_bus_rdata;
    end
    if (rd_en) begin
      rd_tag_q  <= tag_mem[rd_idx];
      rd_data_q <= data_mem[rd_idx];
    end
  end

  assign o_output_tag  = out_tag_q;
  assign o_rdata       = rdata_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_bus_request = bus_req_q;
  assign o_bus_address = bus_addr_q;
endmodule

// File: tb/tb_cpu_icache_direct.sv
// Directed bench for cpu_icache_direct: a reference line model predicts hit/miss
// and data, expected responses are queued at request time and checked on completion.
module tb_cpu_icache_direct;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_input_tag = '0;
  logic [7:0]  o_output_tag;
  logic [31:0] i_address = '0;
  logic [31:0] o_rdata;
  logic        i_flush = 1'b0;
  logic        o_busy;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_ready = 1'b0;

  always #5 clk = ~clk;

  cpu_icache_direct dut (
    .i_clock(clk), .i_reset(rst),
    .i_input_tag(i_input_tag), .o_output_tag(o_output_tag),
    .i_address(i_address), .o_rdata(o_rdata),
    .i_flush(i_flush), .o_busy(o_busy),
    .o_bus_request(o_bus_request), .o_bus_address(o_bus_address),
    .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
  } exp_t;

  exp_t        sb[$];
  bit          m_valid [512];
  logic [20:0] m_tag   [512];
  logic [31:0] m_data  [512];
  int          total = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic void model_invalidate();
    for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
  endfunction

  // Queue the expected response of a request using the reference line model.
  function automatic void expect_req(input logic [7:0] tag, input logic [31:0] addr,
                                     input logic [31:0] fill);
    exp_t e;
    int   idx;
    idx    = int'(addr[10:2]);
    e.tag  = tag;
    e.addr = addr;
    e.hit  = m_valid[idx] && (m_tag[idx] == addr[31:11]);
    e.data = e.hit ? m_data[idx] : fill;
    sb.push_back(e);
  endfunction

  task automatic drive(input logic [7:0] tag, input logic [31:0] addr, input logic [31:0] fill);
    @(negedge clk);
    i_input_tag = tag;
    i_address   = addr;
    expect_req(tag, addr, fill);
  endtask

  task automatic count_sweep(input string name);
    int n = 0;
    bit saw_req = 1'b0;
    while (o_busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (o_bus_request !== 1'b0) saw_req = 1'b1;
    end
    chk({name, "_cycles"}, 64'(n), 64'd512);
    chk({name, "_no_bus_req"}, 64'(saw_req), 64'd0);
    model_invalidate();
  endtask

  // Serve the oldest queued request: follow the DUT, play the bus, compare outputs.
  task automatic serve(input int delay, input bit flush_pulse, input int exp_lat, input int max_wait);
    exp_t        e;
    int          cycles = 0;
    logic [31:0] word_addr;
    e = sb[0];
    word_addr = {e.addr[31:2], 2'b00};
    do begin
      @(negedge clk);
      cycles++;
    end while (o_output_tag !== e.tag && o_bus_request !== 1'b1 && cycles < max_wait);
    chk("response_timeout", 64'(cycles < max_wait), 64'd1);
    if (exp_lat >= 0) chk("first_reaction_latency", 64'(cycles), 64'(exp_lat));
    chk("miss_issues_bus_request", 64'(o_bus_request), 64'(!e.hit));
    if (o_bus_request === 1'b1) begin
      chk("bus_address", 64'(o_bus_address), 64'(word_addr));
      for (int i = 0; i < delay; i++) begin
        if (flush_pulse && i == 0) i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("bus_request_held", 64'(o_bus_request), 64'd1);
        chk("bus_address_stable", 64'(o_bus_address), 64'(word_addr));
      end
      i_bus_ready = 1'b1;
      i_bus_rdata = e.data;
      @(negedge clk);
      i_bus_ready = 1'b0;
      i_bus_rdata = $urandom;
      m_valid[e.addr[10:2]] = 1'b1;
      m_tag[e.addr[10:2]]   = e.addr[31:11];
      m_data[e.addr[10:2]]  = e.data;
      chk("bus_request_dropped", 64'(o_bus_request), 64'd0);
    end
    e = sb.pop_front();
    $display("req tag=%0d addr=%08h %s data=%08h", e.tag, e.addr, e.hit ? "hit" : "miss", e.data);
    chk("output_tag", 64'(o_output_tag), 64'(e.tag));
    chk("rdata", 64'(o_rdata), 64'(e.data));
    if (flush_pulse) begin
      int n = 0;
      while (o_busy !== 1'b1 && n < 4) begin
        @(negedge clk);
        n++;
      end
      chk("flush_started_after_fill", 64'(o_busy), 64'd1);
      count_sweep("pending_flush");
      chk("tag_kept_over_flush", 64'(o_output_tag), 64'(e.tag));
      chk("rdata_kept_over_flush", 64'(o_rdata), 64'(e.data));
    end
  endtask

  initial begin
    int cycles;
    model_invalidate();
    // Reset and the initial invalidation sweep.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_output_tag", 64'(o_output_tag), 64'd0);
    chk("reset_rdata", 64'(o_rdata), 64'd0);
    chk("reset_bus_request", 64'(o_bus_request), 64'd0);
    chk("reset_bus_address", 64'(o_bus_address), 64'd0);
    chk("reset_busy", 64'(o_busy), 64'd1);
    count_sweep("reset_sweep");
    chk("idle_after_sweep", 64'(o_busy), 64'd0);
    chk("tag_after_sweep", 64'(o_output_tag), 64'd0);

    drive(8'd1, 32'h0000_0100, 32'h0000_0013); serve(3, 1'b0, 2, 20);
    drive(8'd2, 32'h0000_0102, 32'h1111_1111); serve(0, 1'b0, 2, 20);
    drive(8'd3, 32'h0000_0900, 32'hDEAD_BEEF); serve(1, 1'b0, 2, 20);
    drive(8'd4, 32'h0000_0100, 32'h0000_0013); serve(0, 1'b0, 2, 20);
    drive(8'd5, 32'h0000_0104, 32'h2222_3333); serve(2, 1'b0, 2, 20);
    drive(8'd6, 32'h0000_0107, 32'h4444_5555); serve(0, 1'b0, 2, 20);
    drive(8'd7, 32'h0000_0208, 32'hCAFE_F00D); serve(2, 1'b1, 2, 20);
    drive(8'd8, 32'h0000_0208, 32'h0BAD_F00D); serve(1, 1'b0, 2, 20);
    drive(8'd9, 32'h0000_0104, 32'h6666_7777); serve(0, 1'b0, 2, 20);

    // Reset during a line fill, then a stray ready while the sweep runs.
    drive(8'd10, 32'h0000_0300, 32'h0000_0055);
    cycles = 0;
    while (o_bus_request !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("abort_miss_reached_bus", 64'(o_bus_request), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_invalidate();
    chk("abort_bus_request", 64'(o_bus_request), 64'd0);
    chk("abort_output_tag", 64'(o_output_tag), 64'd0);
    repeat (3) @(negedge clk);
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h0000_0055;
    @(negedge clk);
    i_bus_ready = 1'b0;
    chk("late_ready_tag", 64'(o_output_tag), 64'd0);
    chk("late_ready_rdata", 64'(o_rdata), 64'd0);
    chk("late_ready_busy", 64'(o_busy), 64'd1);
    $display("reset during fill, stray ready ignored");
    expect_req(8'd10, 32'h0000_0300, 32'h0000_0077);
    serve(1, 1'b0, -1, 700);

    // Tag wrap 255 -> 0 on hits.
    drive(8'd255, 32'h0000_0300, 32'h0);   serve(0, 1'b0, 2, 20);
    drive(8'd0,   32'h0000_0301, 32'h0);   serve(0, 1'b0, 2, 20);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
